// File: rtl/sprite_mem_pkg.sv
// Shared types, constants and width helpers for the sprite pixel store.
package sprite_mem_pkg;

    typedef enum logic {
        IDLE  = 1'b0,
        CLEAR = 1'b1
    } clr_state_t;

    localparam logic [23:0] DEFAULT_TRANSPARENT = 24'hFF00FF;

    // Sprite-index width: at least one bit even for a single sprite.
    function automatic int unsigned calc_sid_w(input int unsigned n_sprites);
        return (n_sprites > 2) ? 32'($clog2(n_sprites)) : 32'd1;
    endfunction

    function automatic int unsigned calc_addr_w(input int unsigned n_sprites,
                                                input int unsigned dim);
        return calc_sid_w(n_sprites) + 32'd2 * 32'($clog2(dim));
    endfunction

endpackage

// File: rtl/sprite_ram_1w1r.sv
// Simple dual-port synchronous RAM: one write port, one registered read port,
// read-during-write returns the old contents. The array itself has no reset.
module sprite_ram_1w1r #(
    parameter int unsigned DATA_W = 8,
    parameter int unsigned ADDR_W = 8
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              we,
    input  logic [ADDR_W-1:0] waddr,
    input  logic [DATA_W-1:0] wdata,
    input  logic              re,
    input  logic [ADDR_W-1:0] raddr,
    output logic [DATA_W-1:0] rdata
);

    logic [DATA_W-1:0] mem [2**ADDR_W];

    always_ff @(posedge clk) begin
        if (we) begin
            mem[waddr] <= wdata;
        end
    end

    // Output register holds its value when no read is issued.
    always_ff @(posedge clk) begin
        if (reset) begin
            rdata <= '0;
        end else if (re) begin
            rdata <= mem[raddr];
        end
    end

endmodule

// File: rtl/sprite_image_mem.sv
// Sprite pixel store: CPU write port, 2-cycle pipelined read port with
// transparency flag, and a bulk-clear engine filling with the colour key.
module sprite_image_mem
    import sprite_mem_pkg::*;
#(
    parameter int unsigned          PIXEL_W     = 24,
    parameter int unsigned          N_SPRITES   = 4,
    parameter int unsigned          SPRITE_DIM  = 16,
    parameter logic [PIXEL_W-1:0]   TRANSPARENT = PIXEL_W'(DEFAULT_TRANSPARENT),
    localparam int unsigned         SID_W       = calc_sid_w(N_SPRITES),
    localparam int unsigned         CW          = $clog2(SPRITE_DIM),
    localparam int unsigned         ADDR_W      = calc_addr_w(N_SPRITES, SPRITE_DIM)
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               wr_en,
    input  logic [SID_W-1:0]   wr_sprite,
    input  logic [CW-1:0]      wr_x,
    input  logic [CW-1:0]      wr_y,
    input  logic [PIXEL_W-1:0] wr_data,
    input  logic               rd_req,
    input  logic [SID_W-1:0]   rd_sprite,
    input  logic [CW-1:0]      rd_x,
    input  logic [CW-1:0]      rd_y,
    output logic [PIXEL_W-1:0] rd_data,
    output logic               rd_valid,
    output logic               rd_transparent,
    input  logic               clr_start,
    output logic               clr_busy,
    output logic               wr_dropped
);

    localparam logic [ADDR_W-1:0] CLR_LAST =
        ADDR_W'(N_SPRITES * SPRITE_DIM * SPRITE_DIM - 1);

    clr_state_t          state_q, state_d;
    logic [ADDR_W-1:0]   cnt_q, cnt_d;

    logic                wr_oor, rd_oor;
    logic                mux_we, drop;
    logic [ADDR_W-1:0]   mux_addr;
    logic [PIXEL_W-1:0]  mux_data;

    // Write stage register: aligns RAM writes with the read pipeline so a
    // read issued in the same cycle as a write still sees the old pixel.
    logic                wq_we;
    logic [ADDR_W-1:0]   wq_addr;
    logic [PIXEL_W:0]    wq_data;

    logic                s0_req, s0_oor, s1_oor;
    logic [ADDR_W-1:0]   s0_addr;
    logic [PIXEL_W:0]    ram_q;

    assign wr_oor = 32'(wr_sprite) >= N_SPRITES;
    assign rd_oor = 32'(rd_sprite) >= N_SPRITES;

    // Clear FSM next-state and write-port mux (CPU vs clear engine).
    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        mux_we   = 1'b0;
        mux_addr = {wr_sprite, wr_y, wr_x};
        mux_data = wr_data;
        drop     = 1'b0;
        case (state_q)
            IDLE: begin
                mux_we = wr_en & ~wr_oor;
                drop   = wr_en & wr_oor;
                if (clr_start) begin
                    state_d = CLEAR;
                    cnt_d   = '0;
                end
            end
            CLEAR: begin
                mux_we   = 1'b1;
                mux_addr = cnt_q;
                mux_data = TRANSPARENT;
                drop     = wr_en;
                cnt_d    = cnt_q + ADDR_W'(1);
                if (cnt_q == CLR_LAST) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q    <= IDLE;
            cnt_q      <= '0;
            clr_busy   <= 1'b0;
            wr_dropped <= 1'b0;
            wq_we      <= 1'b0;
            wq_addr    <= '0;
            wq_data    <= '0;
            s0_req     <= 1'b0;
            s0_oor     <= 1'b0;
            s0_addr    <= '0;
            s1_oor     <= 1'b0;
            rd_valid   <= 1'b0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            clr_busy   <= (state_d == CLEAR);
            wr_dropped <= drop;
            wq_we      <= mux_we;
            wq_addr    <= mux_addr;
            wq_data    <= {mux_data == TRANSPARENT, mux_data};
            s0_req     <= rd_req;
            s0_oor     <= rd_oor;
            s0_addr    <= {rd_sprite, rd_y, rd_x};
            rd_valid   <= s0_req;
            if (s0_req) begin
                s1_oor <= s0_oor;
            end
        end
    end

    // Stored word carries a precomputed key-match bit above the pixel.
    sprite_ram_1w1r #(
        .DATA_W (PIXEL_W + 1),
        .ADDR_W (ADDR_W)
    ) u_ram (
        .clk   (clk),
        .reset (reset),
        .we    (wq_we),
        .waddr (wq_addr),
        .wdata (wq_data),
        .re    (s0_req),
        .raddr (s0_addr),
        .rdata (ram_q)
    );

    assign rd_data        = s1_oor ? TRANSPARENT : ram_q[PIXEL_W-1:0];
    assign rd_transparent = s1_oor | ram_q[PIXEL_W];

endmodule
